// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 width codes,
// datapath width and the responder FSM state encoding.
package rv32i_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane logic: merges store data into the addressed word,
// extracts and extends load data, and flags illegal widths.
// Optional macro DMEM_MISALIGN_CHECK_EN also rejects misaligned half/word accesses.
module dmem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic              write_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] wword_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sx;
    sb = b;
    sx = sb;
    return sgn ? sx : {24'd0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sx;
    sh = h;
    sx = sh;
    return sgn ? sx : {16'd0, h};
  endfunction

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        illegal;
  logic        misalign;

  // Lane selection, width legality, store merge and load extension
  always_comb begin
    byte_v   = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_v   = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
    illegal  = 1'b0;
    misalign = 1'b0;
    case (funct3_i)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = write_i;
      default:          illegal = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    if (funct3_i[1:0] == 2'b01 && addr_lo_i[0])      misalign = 1'b1;
    if (funct3_i[1:0] == 2'b10 && addr_lo_i != 2'b00) misalign = 1'b1;
`endif
    err_o = illegal | misalign;

    wword_o = rword_i;
    case (funct3_i)
      F3_B:    wword_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H:    wword_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      F3_W:    wword_o = wdata_i;
      default: wword_o = rword_i;
    endcase

    rdata_o = '0;
    if (!write_i && !err_o) begin
      case (funct3_i)
        F3_B:    rdata_o = ext_byte(byte_v, 1'b1);
        F3_BU:   rdata_o = ext_byte(byte_v, 1'b0);
        F3_H:    rdata_o = ext_half(half_v, 1'b1);
        F3_HU:   rdata_o = ext_half(half_v, 1'b0);
        F3_W:    rdata_o = rword_i;
        default: rdata_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY from accept to
// response, response held until consumed. Owns the data array.
// Optional macro DMEM_MISALIGN_CHECK_EN (handled in dmem_lane_align).
module dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [AW+1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              error_q;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [2:0]        acc_f3;
  logic [AW+1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] ld_data;
  logic              acc_err;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  // With LATENCY=1 the access happens on the accept edge, so it must use the
  // live request fields; otherwise it uses the latched ones.
  assign acc_write = (state_q == IDLE) ? req_write        : write_q;
  assign acc_f3    = (state_q == IDLE) ? req_funct3       : f3_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata        : wdata_q;
  assign rd_word   = mem[acc_addr[AW+1:2]];

  dmem_lane_align u_align (
    .write_i   (acc_write),
    .funct3_i  (acc_f3),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (rd_word),
    .wword_o   (wr_word),
    .rdata_o   (ld_data),
    .err_o     (acc_err)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  // State, counter and response registers; response captured on the RESP-entry edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        rdata_q <= ld_data;
        error_q <= acc_err;
      end
    end
  end

  // Request field latches
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  // Array write on the RESP-entry edge; suppressed by reset and by errors
  always_ff @(posedge clk) begin
    if (!rst && access && acc_write && !acc_err) begin
      mem[acc_addr[AW+1:2]] <= wr_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-addressed reference model.
module tb_dmem_responder;
  import rv32i_mem_pkg::*;

  localparam int     DEPTH = 1024;
  localparam int     LAT   = 2;
  localparam longint MEMB  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  // Reference model: memory as individual bytes, accesses as naturally sized chunks.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nb;
    int base;
    bit legal;
    logic [63:0] v;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (w) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   legal = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % nb) != 0) legal = 0;
`endif
    base = int'(a % MEMB);
    base = base - (base % nb);
    rd = 32'd0;
    er = !legal;
    if (!legal) return;
    if (w) begin
      for (int i = 0; i < nb; i++) mem_m[base + i] = wd[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v = v | (64'(mem_m[base + i]) << (8*i));
      if (!f3[2] && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (resp_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL txn_timeout: resp_valid=%b required 1", resp_valid);
    end
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b required 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b required 0", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_rdata: got %h required 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_error !== 1'b0) $display("FAIL rst_error: got %b required 0", resp_error); else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_checks++; if (er !== 1'b0 || rd !== 32'd0) $display("FAIL sw_resp: got err=%b rdata=%h required 0/0", er, rd); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL sw_latency: got %0d required %0d", lat, LAT); else n_pass++;
    do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_word: got %h/%b required deadbeef/0", rd, er); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL lw_latency: got %0d required %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, F3_B, 32'h13, 32'h80, rd, er, lat);
    do_txn(1'b0, F3_B, 32'h13, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) $display("FAIL lb: got %h/%b required ffffff80/0", rd, er); else n_pass++;
    do_txn(1'b0, F3_BU, 32'h13, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h00000080 || er !== 1'b0) $display("FAIL lbu: got %h/%b required 00000080/0", rd, er); else n_pass++;
    do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h80ADBEEF) $display("FAIL lw_after_sb: got %h required 80adbeef", rd); else n_pass++;
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, F3_W, 32'h20, 32'hCAFE1234, rd, er, lat);
    do_txn(1'b1, F3_H, 32'h22, 32'h8001, rd, er, lat);
    do_txn(1'b0, F3_H, 32'h22, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'hFFFF8001 || er !== 1'b0) $display("FAIL lh: got %h/%b required ffff8001/0", rd, er); else n_pass++;
    do_txn(1'b0, F3_HU, 32'h22, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h00008001 || er !== 1'b0) $display("FAIL lhu: got %h/%b required 00008001/0", rd, er); else n_pass++;
    do_txn(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h80011234) $display("FAIL sh_low_half_kept: got %h required 80011234", rd); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL load_f3_011: got err=%b rdata=%h required 1/0", er, rd); else n_pass++;
    do_txn(1'b1, F3_BU, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL store_f3_100: got err=%b rdata=%h required 1/0", er, rd); else n_pass++;
    do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h80ADBEEF) $display("FAIL illegal_store_no_write: got %h required 80adbeef", rd); else n_pass++;
    do_txn(1'b0, F3_W, 32'h11, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL lw_misaligned: got err=%b rdata=%h required 1/0", er, rd); else n_pass++;
`else
    n_checks++; if (er !== 1'b0 || rd !== 32'h80ADBEEF) $display("FAIL lw_unaligned: got err=%b rdata=%h required 0/80adbeef", er, rd); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++; if (resp_rdata !== 32'h80ADBEEF) $display("FAIL bp_rdata: got %h required 80adbeef", resp_rdata); else n_pass++;
    // Competing store held on the request port while the response is stalled.
    req_write = 1'b1; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h80ADBEEF || req_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: valid=%b rdata=%h req_ready=%b required 1/80adbeef/0", i, resp_valid, resp_rdata, req_ready);
      else n_pass++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release: valid=%b req_ready=%b required 0/1", resp_valid, req_ready); else n_pass++;
    do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h80ADBEEF) $display("FAIL bp_store_not_taken: got %h required 80adbeef", rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int n;
    do_txn(1'b1, F3_W, 32'h30, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h30; req_wdata = 32'h12345678;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rst_wait: req_ready=%b valid=%b required 1/0", req_ready, resp_valid); else n_pass++;
    do_txn(1'b0, F3_W, 32'h30, 32'h0, rd, er, lat);
    n_checks++; if (rd !== 32'h0) $display("FAIL rst_wait_no_write: got %h required 0", rd); else n_pass++;
    // Reset while a response is pending drops it.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_resp: valid=%b req_ready=%b required 0/1", resp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic er, eer, w; logic [2:0] f3; int lat;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, F3_W, 32'h200 + 32'(4*i), wd, erd, eer);
      do_txn(1'b1, F3_W, 32'h200 + 32'(4*i), wd, rd, er, lat);
    end
    for (int i = 0; i < 80; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h200 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 15)) << 12);
      wd = $urandom;
      model(w, f3, a, wd, erd, eer);
      do_txn(w, f3, a, wd, rd, er, lat);
      n_checks++;
      if (rd !== erd || er !== eer || lat != LAT)
        $display("FAIL rand_%0d: w=%b f3=%0d a=%h got %h/%b/lat%0d required %h/%b/lat%0d", i, w, f3, a, rd, er, lat, erd, eer, LAT);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
